// File: rtl/mem_write_seq_checker.sv
// mem_write_seq_checker: snoops the data-memory write port and checks that a window of
// COUNT words, starting at BASE_ADDR and spaced STRIDE bytes apart, receives a generated
// sequence in index order. MODE 0 generates Fibonacci (e[i] = e[i-1] + e[i-2]). MODE 1
// generates an arithmetic sequence (e[i] = e[i-1] + SEED1). It reports pass/fail, the failing
// index, the expected and observed data and the error cause. It is FPGA-safe (no $display).
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_enable       arms the checker; low returns it to idle and clears all results
//   i_memwrite     write strobe
//   i_dataadr      write byte address
//   i_writedata    write data
//   o_done         o_pass | o_fail
//   o_pass         all COUNT elements matched
//   o_fail         error detected (sticky)
//   o_err_code     0 none, 1 data mismatch, 2 out-of-order, 3 misaligned, 4 timeout
//   o_err_index    element index at the failure
//   o_err_expected expected value at the failure
//   o_err_actual   observed data at the failure (0 for timeout)
//   o_match_count  elements matched so far
module mem_write_seq_checker #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned COUNT     = 10,
  parameter int unsigned BASE_ADDR = 100,
  parameter int unsigned STRIDE    = 4,
  parameter int unsigned MODE      = 0,
  parameter int unsigned SEED0     = 0,
  parameter int unsigned SEED1     = 1,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic                       i_memwrite,
  input  logic [ADDR_W-1:0]          i_dataadr,
  input  logic [WIDTH-1:0]           i_writedata,
  output logic                       o_done,
  output logic                       o_pass,
  output logic                       o_fail,
  output logic [2:0]                 o_err_code,
  output logic [$clog2(COUNT)-1:0]   o_err_index,
  output logic [WIDTH-1:0]           o_err_expected,
  output logic [WIDTH-1:0]           o_err_actual,
  output logic [$clog2(COUNT+1)-1:0] o_match_count
);

  localparam int unsigned IdxW  = $clog2(COUNT);
  localparam int unsigned McW   = $clog2(COUNT + 1);
  localparam int unsigned Shift = $clog2(STRIDE);

  // One extra address bit so the window end cannot wrap.
  localparam logic [ADDR_W:0] WinLo = (ADDR_W + 1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] WinHi = (ADDR_W + 1)'(BASE_ADDR) + (ADDR_W + 1)'(COUNT * STRIDE);

  localparam logic [WIDTH-1:0] InitCur = WIDTH'(SEED0);
  localparam logic [WIDTH-1:0] InitNxt = (MODE == 0) ? WIDTH'(SEED1)
                                                     : WIDTH'(SEED0) + WIDTH'(SEED1);

  typedef enum logic [1:0] {StIdle, StArmed, StPass, StFail} state_e;

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_e_cur, w_e_cur_d;
  logic [WIDTH-1:0]   r_e_nxt, w_e_nxt_d;
  logic [IdxW-1:0]    r_next_idx, w_next_idx_d;
  logic [31:0]        r_timer, w_timer_d;
  logic [McW-1:0]     r_match_count, w_match_count_d;
  logic               r_pass, w_pass_d;
  logic               r_fail, w_fail_d;
  logic [2:0]         r_err_code, w_err_code_d;
  logic [IdxW-1:0]    r_err_index, w_err_index_d;
  logic [WIDTH-1:0]   r_err_exp, w_err_exp_d;
  logic [WIDTH-1:0]   r_err_act, w_err_act_d;

  logic [ADDR_W-1:0]  w_off;
  logic [IdxW-1:0]    w_idx;
  logic               w_hit;
  logic               w_misal;
  logic               w_timeout;
  logic [2:0]         w_cause;

  assign w_off   = i_dataadr - ADDR_W'(BASE_ADDR);
  // An in-window index is always < COUNT, so the truncation cannot alias.
  assign w_idx   = IdxW'(w_off >> Shift);
  assign w_misal = (w_off & ADDR_W'(STRIDE - 1)) != '0;
  assign w_hit   = i_memwrite && ({1'b0, i_dataadr} >= WinLo) && ({1'b0, i_dataadr} < WinHi);
  assign w_timeout = (TIMEOUT != 0) && (r_timer == 32'(TIMEOUT - 1));

  always_comb begin
    w_state_d       = r_state;
    w_e_cur_d       = r_e_cur;
    w_e_nxt_d       = r_e_nxt;
    w_next_idx_d    = r_next_idx;
    w_timer_d       = r_timer;
    w_match_count_d = r_match_count;
    w_pass_d        = r_pass;
    w_fail_d        = r_fail;
    w_err_code_d    = r_err_code;
    w_err_index_d   = r_err_index;
    w_err_exp_d     = r_err_exp;
    w_err_act_d     = r_err_act;
    w_cause         = 3'd0;

    unique case (r_state)
      StIdle: begin
        if (i_enable) w_state_d = StArmed;
      end
      StArmed: begin
        if (w_hit && w_misal)                      w_cause = 3'd3;
        else if (w_hit && (w_idx != r_next_idx))   w_cause = 3'd2;
        else if (w_hit && (i_writedata != r_e_cur)) w_cause = 3'd1;
        else if (!w_hit && w_timeout)              w_cause = 3'd4;

        if (w_cause != 3'd0) begin
          w_state_d     = StFail;
          w_fail_d      = 1'b1;
          w_err_code_d  = w_cause;
          w_err_index_d = (w_cause == 3'd4) ? r_next_idx : w_idx;
          w_err_exp_d   = r_e_cur;
          w_err_act_d   = (w_cause == 3'd4) ? '0 : i_writedata;
        end else if (w_hit) begin
          // A match always wins over a timeout in the same cycle.
          w_match_count_d = r_match_count + McW'(1);
          w_next_idx_d    = r_next_idx + IdxW'(1);
          w_timer_d       = '0;
          w_e_cur_d       = r_e_nxt;
          w_e_nxt_d       = (MODE == 0) ? r_e_cur + r_e_nxt : r_e_nxt + WIDTH'(SEED1);
          if (r_next_idx == IdxW'(COUNT - 1)) begin
            w_state_d = StPass;
            w_pass_d  = 1'b1;
          end
        end else begin
          w_timer_d = r_timer + 32'd1;
        end
      end
      StPass, StFail: begin
      end
      default: w_state_d = StIdle;
    endcase

    // Idle keeps the generator primed so arming always starts from the seeds.
    if (r_state == StIdle || !i_enable) begin
      w_e_cur_d    = InitCur;
      w_e_nxt_d    = InitNxt;
      w_next_idx_d = '0;
      w_timer_d    = '0;
    end

    if (!i_enable) begin
      w_state_d       = StIdle;
      w_match_count_d = '0;
      w_pass_d        = 1'b0;
      w_fail_d        = 1'b0;
      w_err_code_d    = 3'd0;
      w_err_index_d   = '0;
      w_err_exp_d     = '0;
      w_err_act_d     = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_e_cur       <= InitCur;
      r_e_nxt       <= InitNxt;
      r_next_idx    <= '0;
      r_timer       <= '0;
      r_match_count <= '0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_err_code    <= 3'd0;
      r_err_index   <= '0;
      r_err_exp     <= '0;
      r_err_act     <= '0;
    end else begin
      r_state       <= w_state_d;
      r_e_cur       <= w_e_cur_d;
      r_e_nxt       <= w_e_nxt_d;
      r_next_idx    <= w_next_idx_d;
      r_timer       <= w_timer_d;
      r_match_count <= w_match_count_d;
      r_pass        <= w_pass_d;
      r_fail        <= w_fail_d;
      r_err_code    <= w_err_code_d;
      r_err_index   <= w_err_index_d;
      r_err_exp     <= w_err_exp_d;
      r_err_act     <= w_err_act_d;
    end
  end

  assign o_done         = r_pass | r_fail;
  assign o_pass         = r_pass;
  assign o_fail         = r_fail;
  assign o_err_code     = r_err_code;
  assign o_err_index    = r_err_index;
  assign o_err_expected = r_err_exp;
  assign o_err_actual   = r_err_act;
  assign o_match_count  = r_match_count;

endmodule

// File: tb/tb_mem_write_seq_checker.sv
// Directed bench for mem_write_seq_checker. Four instances with different parameter sets
// share clock, reset and the write bus; each has its own enable so only one is armed at a time.
module tb_mem_write_seq_checker;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] wdata;

  // u_def: defaults
  logic        d_done, d_pass, d_fail;
  logic [2:0]  d_code;
  logic [3:0]  d_idx, d_mc;
  logic [31:0] d_exp, d_act;
  // u_to: TIMEOUT=20
  logic        t_done, t_pass, t_fail;
  logic [2:0]  t_code;
  logic [3:0]  t_idx, t_mc;
  logic [31:0] t_exp, t_act;
  // u_w8: WIDTH=8, COUNT=15
  logic        w_done, w_pass, w_fail;
  logic [2:0]  w_code;
  logic [3:0]  w_idx, w_mc;
  logic [7:0]  w_exp, w_act;
  // u_ar: MODE=1, SEED0=7, SEED1=3, COUNT=4
  logic        a_done, a_pass, a_fail;
  logic [2:0]  a_code;
  logic [1:0]  a_idx;
  logic [2:0]  a_mc;
  logic [31:0] a_exp, a_act;

  int unsigned fib [15] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377};

  int n_checks = 0;
  int n_pass   = 0;

  mem_write_seq_checker u_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[0]), .i_memwrite(memwrite),
    .i_dataadr(dataadr), .i_writedata(wdata), .o_done(d_done), .o_pass(d_pass),
    .o_fail(d_fail), .o_err_code(d_code), .o_err_index(d_idx), .o_err_expected(d_exp),
    .o_err_actual(d_act), .o_match_count(d_mc)
  );

  mem_write_seq_checker #(.TIMEOUT(20)) u_to (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[1]), .i_memwrite(memwrite),
    .i_dataadr(dataadr), .i_writedata(wdata), .o_done(t_done), .o_pass(t_pass),
    .o_fail(t_fail), .o_err_code(t_code), .o_err_index(t_idx), .o_err_expected(t_exp),
    .o_err_actual(t_act), .o_match_count(t_mc)
  );

  mem_write_seq_checker #(.WIDTH(8), .COUNT(15)) u_w8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[2]), .i_memwrite(memwrite),
    .i_dataadr(dataadr), .i_writedata(wdata[7:0]), .o_done(w_done), .o_pass(w_pass),
    .o_fail(w_fail), .o_err_code(w_code), .o_err_index(w_idx), .o_err_expected(w_exp),
    .o_err_actual(w_act), .o_match_count(w_mc)
  );

  mem_write_seq_checker #(.MODE(1), .SEED0(7), .SEED1(3), .COUNT(4)) u_ar (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[3]), .i_memwrite(memwrite),
    .i_dataadr(dataadr), .i_writedata(wdata), .o_done(a_done), .o_pass(a_pass),
    .o_fail(a_fail), .o_err_code(a_code), .o_err_index(a_idx), .o_err_expected(a_exp),
    .o_err_actual(a_act), .o_match_count(a_mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // All tasks start and end just after a falling edge; a write is sampled on the
  // rising edge inside wr(), so back-to-back wr() calls hit consecutive edges.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    dataadr  = a;
    wdata    = d;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm(input int unsigned k);
    en    = 4'b0;
    idle(2);
    en[k] = 1'b1;
    idle(1);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 4'b0;
    memwrite = 1'b0;
    dataadr  = '0;
    wdata    = '0;
    idle(2);
    check("rst_pass", 32'(d_pass), 0);
    check("rst_fail", 32'(d_fail), 0);
    check("rst_done", 32'(d_done), 0);
    check("rst_code", 32'(d_code), 0);
    check("rst_mc",   32'(d_mc),   0);
    rst_n = 1'b1;
    idle(1);

    // Full Fibonacci pass with interleaved out-of-window writes
    arm(0);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        check("fib_pass_early", 32'(d_pass), 0);
        check("fib_mc9", 32'(d_mc), 9);
      end
      wr(32'(100 + 4 * i), fib[i]);
      wr(40, 32'hdead);
      idle(1);
    end
    check("fib_pass", 32'(d_pass), 1);
    check("fib_done", 32'(d_done), 1);
    check("fib_fail", 32'(d_fail), 0);
    check("fib_mc", 32'(d_mc), 10);
    wr(100, 7);
    check("fib_sticky", 32'(d_pass), 1);
    check("fib_sticky_fail", 32'(d_fail), 0);
    en[0] = 1'b0;
    idle(1);
    check("dis_pass", 32'(d_pass), 0);
    check("dis_mc", 32'(d_mc), 0);

    // Data mismatch at idx 5
    arm(0);
    for (int i = 0; i < 5; i++) wr(32'(100 + 4 * i), fib[i]);
    wr(120, 6);
    check("mm_fail", 32'(d_fail), 1);
    check("mm_code", 32'(d_code), 1);
    check("mm_idx", 32'(d_idx), 5);
    check("mm_exp", d_exp, 5);
    check("mm_act", d_act, 6);
    check("mm_mc", 32'(d_mc), 5);
    wr(120, 5);
    check("mm_sticky", 32'(d_fail), 1);
    check("mm_sticky_act", d_act, 6);

    // Out-of-order index
    arm(0);
    wr(100, 0);
    wr(108, 1);
    check("ooo_code", 32'(d_code), 2);
    check("ooo_idx", 32'(d_idx), 2);
    check("ooo_mc", 32'(d_mc), 1);
    check("ooo_exp", d_exp, 1);

    // Misaligned address
    arm(0);
    wr(102, 0);
    check("mis_code", 32'(d_code), 3);
    check("mis_fail", 32'(d_fail), 1);
    check("mis_idx", 32'(d_idx), 0);

    // Timeout 20 cycles after the last match
    arm(1);
    wr(100, 0);
    idle(19);
    check("to_not_yet", 32'(t_fail), 0);
    idle(1);
    check("to_fail", 32'(t_fail), 1);
    check("to_code", 32'(t_code), 4);
    check("to_idx", 32'(t_idx), 1);
    check("to_exp", t_exp, 1);
    check("to_act", t_act, 0);

    // Match on the would-be timeout edge wins
    arm(1);
    wr(100, 0);
    idle(19);
    wr(104, 1);
    check("to_save_fail", 32'(t_fail), 0);
    check("to_save_mc", 32'(t_mc), 2);
    idle(19);
    check("to2_not_yet", 32'(t_fail), 0);
    idle(1);
    check("to2_code", 32'(t_code), 4);
    check("to2_idx", 32'(t_idx), 2);

    // 8-bit wrap with 15 elements
    arm(2);
    for (int i = 0; i < 15; i++) wr(32'(100 + 4 * i), fib[i] & 32'hff);
    check("w8_pass", 32'(w_pass), 1);
    check("w8_mc", 32'(w_mc), 15);
    arm(2);
    for (int i = 0; i < 14; i++) wr(32'(100 + 4 * i), fib[i] & 32'hff);
    wr(156, 122);
    check("w8_code", 32'(w_code), 1);
    check("w8_idx", 32'(w_idx), 14);
    check("w8_exp", 32'(w_exp), 121);
    check("w8_act", 32'(w_act), 122);

    // Arithmetic sequence
    arm(3);
    for (int i = 0; i < 4; i++) wr(32'(100 + 4 * i), 32'(7 + 3 * i));
    check("ar_pass", 32'(a_pass), 1);
    check("ar_mc", 32'(a_mc), 4);

    // Asynchronous reset mid-sequence, then re-run with enable held
    arm(3);
    wr(100, 7);
    wr(104, 10);
    check("ar_mc2", 32'(a_mc), 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mc", 32'(a_mc), 0);
    check("arst_done", 32'(a_done), 0);
    check("arst_code", 32'(a_code), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) wr(32'(100 + 4 * i), 32'(7 + 3 * i));
    check("ar2_pass", 32'(a_pass), 1);
    check("ar2_fail", 32'(a_fail), 0);
    check("ar2_mc", 32'(a_mc), 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_write_seq_checker.md
Name: mem_write_seq_checker

Overview:
- Synthesizable self-checking monitor that snoops the data-memory write port of the computer (memwrite/dataadr/writedata).
- Checks that a parametrised window of words receives an expected generated sequence: Fibonacci or arithmetic, with configurable width, length, base, stride and seeds.
- Reports pass/fail, error location and error cause.
- Used both in simulation benches and on FPGA builds, where there is no $display.

Parameters:
WIDTH, 32, data width of writedata and of the expected-value generator
ADDR_W, 32, address width of dataadr
COUNT, 10, number of sequence elements checked (>=2)
BASE_ADDR, 100, byte address of element 0
STRIDE, 4, byte spacing between elements; power of two
MODE, 0, 0 = Fibonacci (e[i]=e[i-1]+e[i-2]); 1 = arithmetic (e[i]=e[i-1]+SEED1)
SEED0, 0, e[0]
SEED1, 1, e[1] in Fibonacci mode; step value in arithmetic mode
TIMEOUT, 1000, max cycles without progress while armed; 0 disables the timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  arms the checker; low returns it to IDLE
memwrite  input  1  write strobe from the computer
dataadr  input  ADDR_W  write byte address
writedata  input  WIDTH  write data
done  output  1  pass | fail
pass  output  1  all COUNT elements matched
fail  output  1  error detected (sticky)
err_code  output  3  0 none, 1 data mismatch, 2 out-of-order index, 3 misaligned address, 4 timeout
err_index  output  clog2(COUNT)  element index at the failure
err_expected  output  WIDTH  expected value at the failure
err_actual  output  WIDTH  observed writedata at the failure
match_count  output  clog2(COUNT+1)  elements matched so far

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Generator loaded with e_cur=SEED0; e_nxt=SEED1 (MODE 0) or SEED0+SEED1 (MODE 1).
  - next_idx=0; timer=0.
- States: IDLE, ARMED, PASS, FAIL.
  - IDLE -> ARMED when enable=1. Generator, next_idx and timer are reloaded on this transition.
  - Any state -> IDLE when enable=0. All outputs are cleared on the next edge.
- Window: an address is in the window when BASE_ADDR <= dataadr < BASE_ADDR+COUNT*STRIDE.
  - Offset off = dataadr - BASE_ADDR.
  - Index idx = off / STRIDE (shift).
  - Misaligned when off & (STRIDE-1) != 0.
- In ARMED, a sampled write is memwrite=1 at a rising edge. Writes outside the window are ignored. For a write inside the window, in priority order:
  1. Misaligned -> FAIL, code 3.
  2. idx != next_idx -> FAIL, code 2.
  3. writedata != e_cur -> FAIL, code 1.
  4. Otherwise it is a match:
     - match_count+1, next_idx+1, timer=0.
     - Generator advances: MODE 0: e_cur<=e_nxt, e_nxt<=e_cur+e_nxt. MODE 1: e_cur<=e_nxt, e_nxt<=e_nxt+SEED1.
     - All arithmetic is modulo 2^WIDTH (wrap, no saturation).
     - If the matched idx = COUNT-1 -> PASS.
- On entering FAIL:
  - err_index = idx. For timeout, err_index = next_idx.
  - err_expected = e_cur.
  - err_actual = writedata. For timeout, err_actual = 0.
- Timeout: in ARMED the timer increments every cycle without a match. When timer reaches TIMEOUT-1 and no match occurs in that cycle -> FAIL, code 4.
- Same-cycle timeout and match: the match wins and the timer clears.
- PASS and FAIL are sticky. Later writes are ignored and all err_* and match_count values hold until enable=0 or reset.
- Latency: pass/fail/err_* update at the same rising edge that samples the deciding write, so they are visible in the following cycle. done is combinational OR of the registered pass and fail.
- Reset asserted mid-sequence clears everything immediately, with no partial result retained. After reset release with enable held high, the checker arms on the first edge.
- memwrite while IDLE is ignored.

Test Plan:
- Defaults, enable=1; write Fibonacci 0,1,1,2,3,5,8,13,21,34 to addresses 100,104,...,136, one write every 3 cycles, interleaved with writes to address 40 -> pass=1 after the write to 136; match_count=10; fail=0.
- Defaults; correct writes for idx 0-4, then 6 to address 120 -> fail=1, err_code=1, err_index=5, err_expected=5, err_actual=6; a later write of 5 to 120 does not clear fail.
- Defaults; write 0 to 100, then 1 to 108 -> err_code=2, err_index=2, match_count=1. In a separate run, a write to 102 -> err_code=3.
- TIMEOUT=20; one correct write to 100, then idle -> fail with err_code=4 and err_index=1 exactly 20 cycles after the matching edge. A match landing on cycle 19 prevents the fail.
- WIDTH=8, COUNT=15; write F(0..14) mod 256 (last two 233, 121) to addresses 100-156 -> pass=1. Writing 377's wrong truncation 122 at idx 14 -> err_code=1, err_expected=121.
- MODE=1, SEED0=7, SEED1=3, COUNT=4; write 7,10,13,16 -> pass. In a separate run, assert reset low after 2 matches -> all outputs 0 asynchronously; release and rewrite the full sequence -> pass.
